// File: rtl/fifo_rr_drain.sv
// fifo_rr_drain: round-robin burst drain of NUM_FIFOS show-ahead FIFOs into one registered valid/ready stream
module fifo_rr_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_FIFOS  = 4,
  parameter int MAX_BURST  = 4,
  localparam int SRC_W     = (NUM_FIFOS > 1) ? $clog2(NUM_FIFOS) : 1
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_dout,
  output logic [NUM_FIFOS-1:0]            fifo_rd_en,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [DATA_WIDTH-1:0]           m_data,
  output logic [SRC_W-1:0]                m_src
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, BURST} state_t;
  state_t                r_state;
  logic [SRC_W-1:0]      r_grant;
  logic [SRC_W-1:0]      r_last;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_valid;
  logic [DATA_WIDTH-1:0] r_data;
  logic [SRC_W-1:0]      r_src;
  logic                  w_found;
  logic [SRC_W-1:0]      w_next;
  logic                  w_load_ok;
  logic                  w_gnt_empty;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_word;
  assign m_valid     = r_valid;
  assign m_data      = r_data;
  assign m_src       = r_src;
  assign w_load_ok   = !r_valid || m_ready;
  assign w_gnt_empty = fifo_empty[r_grant];
  assign w_pop       = (r_state == BURST) && w_load_ok && !w_gnt_empty;
  assign fifo_rd_en  = w_pop ? (NUM_FIFOS'(1) << r_grant) : '0;
  assign w_word      = fifo_dout[int'(r_grant)*DATA_WIDTH +: DATA_WIDTH];
  // first non-empty FIFO after the last grant, wrapping modulo NUM_FIFOS
  always_comb begin
    w_found = 1'b0;
    w_next  = '0;
    for (int k = 1; k <= NUM_FIFOS; k++)
      if (!w_found && !fifo_empty[(int'(r_last) + k) % NUM_FIFOS]) begin
        w_found = 1'b1;
        w_next  = SRC_W'((int'(r_last) + k) % NUM_FIFOS);
      end
  end
  // output register plus IDLE/BURST arbitration FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= SRC_W'(NUM_FIFOS - 1);
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_src   <= '0;
    end else begin
      if (w_pop) begin
        r_valid <= 1'b1;
        r_data  <= w_word;
        r_src   <= r_grant;
      end else if (m_ready) begin
        r_valid <= 1'b0;
      end
      if (r_state == IDLE) begin
        if (w_found) begin
          r_grant <= w_next;
          r_last  <= w_next;
          r_cnt   <= '0;
          r_state <= BURST;
        end
      end else if (w_gnt_empty) begin
        r_state <= IDLE;
      end else if (w_pop) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CNT_W'(MAX_BURST - 1)) r_state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_fifo_rr_drain.sv
// tb_fifo_rr_drain: FIFO-bank model, scoreboard and directed/random checks for fifo_rr_drain
module tb_fifo_rr_drain;
  localparam int N = 4, W = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] fifo_empty, fifo_rd_en;
  logic [N*W-1:0] fifo_dout;
  logic m_valid, m_ready = 1'b1;
  logic [W-1:0] m_data;
  logic [1:0] m_src;
  typedef logic [7:0] bq_t[$];
  bq_t q[N];
  bq_t sb[N];
  int n_tests = 0, n_fail = 0, cyc = 0, delivered = 0, rfv = 0;
  int popcnt[N];
  int pop_src[$], log_d[$], log_s[$], log_c[$];
  logic refill1 = 1'b0;
  always #5 clk = ~clk;
  fifo_rr_drain #(.DATA_WIDTH(W), .NUM_FIFOS(N), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
    .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_src(m_src)
  );
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      fifo_empty[i] = (q[i].size() == 0);
      fifo_dout[i*W +: W] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  endtask
  task automatic push(input int i, input logic [7:0] w);
    q[i].push_back(w);
    sb[i].push_back(w);
    drive();
  endtask
  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      sb[i].delete();
      popcnt[i] = 0;
    end
    pop_src.delete();
    log_d.delete();
    log_s.delete();
    log_c.delete();
    delivered = 0;
    refill1 = 1'b0;
    drive();
  endtask
  function automatic int remaining();
    int r = 0;
    for (int i = 0; i < N; i++) r += sb[i].size();
    return r;
  endfunction
  task automatic tick();
    logic [N-1:0] pend;
    logic hs, stall;
    logic [W-1:0] hd, w;
    logic [1:0] hsrc;
    #1;
    pend = fifo_rd_en;
    hs = m_valid && m_ready;
    stall = m_valid && !m_ready;
    hd = m_data;
    hsrc = m_src;
    chk("rden_onehot", 32'($countones(pend) <= 1), 32'd1);
    for (int i = 0; i < N; i++)
      if (pend[i]) chk("rden_nonempty", 32'(fifo_empty[i]), 32'd0);
    if (stall) chk("stall_nopop", 32'(pend), 32'd0);
    @(posedge clk);
    #1;
    if (hs) begin
      delivered++;
      log_d.push_back(int'(hd));
      log_s.push_back(int'(hsrc));
      log_c.push_back(cyc);
      if (sb[hsrc].size() == 0) chk("sb_underflow", 32'(hsrc), 32'hFF);
      else chk("order", 32'(hd), 32'(sb[hsrc].pop_front()));
    end
    for (int i = 0; i < N; i++)
      if (pend[i] && q[i].size() > 0) begin
        popcnt[i]++;
        pop_src.push_back(i);
        w = q[i].pop_front();
        chk("lat_valid", 32'(m_valid), 32'd1);
        chk("lat_src", 32'(m_src), 32'(i));
        chk("lat_data", 32'(m_data), 32'(w));
      end
    if (stall) chk("stall_hold", 32'({m_valid, m_data, m_src}), 32'({1'b1, hd, hsrc}));
    if (refill1)
      while (q[1].size() < 3) begin
        push(1, 8'(8'h80 + rfv));
        rfv++;
      end
    drive();
    cyc++;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    m_ready = 1'b1;
    clear_all();
    @(posedge clk);
    #1;
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_src", 32'(m_src), 32'd0);
    chk("rst_rden", 32'(fifo_rd_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc = 0;
  endtask
  initial begin
    int n, kend, pushed3;
    int exp5[6] = '{1, 1, 1, 1, 3, 1};
    drive();
    // preloaded bank: exact word order, sources and timing
    do_reset();
    for (int f = 0; f < N; f++)
      for (int k = 0; k < 6; k++) push(f, 8'(f*16 + k));
    tick();
    chk("idle_valid", 32'(m_valid), 32'd0);
    #1;
    chk("first_grant", 32'(fifo_rd_en), 32'b0001);
    for (int t = 0; t < 80 && log_d.size() < 24; t++) tick();
    chk("seq_len", 32'(log_d.size()), 32'd24);
    n = 0;
    for (int r = 0; r < 2; r++)
      for (int f = 0; f < N; f++) begin
        kend = (r == 0) ? 4 : 6;
        for (int k = r*4; k < kend; k++) begin
          if (n < log_d.size()) begin
            chk("seq_data", 32'(log_d[n]), 32'(f*16 + k));
            chk("seq_src", 32'(log_s[n]), 32'(f));
            if (n < 16) chk("seq_cycle", 32'(log_c[n]), 32'(2 + n + n/4));
          end
          n++;
        end
      end
    // backpressure mid-burst
    do_reset();
    for (int k = 0; k < 6; k++) push(0, 8'(8'hA0 + k));
    for (int t = 0; t < 20 && !(m_valid && m_data == 8'hA1); t++) tick();
    chk("bp_reach", 32'(m_data), 32'hA1);
    m_ready = 1'b0;
    repeat (5) tick();
    #1;
    chk("bp_hold", 32'({m_valid, m_data}), 32'({1'b1, 8'hA1}));
    chk("bp_rden", 32'(fifo_rd_en), 32'd0);
    m_ready = 1'b1;
    tick();
    chk("bp_next_valid", 32'(m_valid), 32'd1);
    chk("bp_next", 32'(m_data), 32'hA2);
    repeat (20) tick();
    chk("bp_count", 32'(delivered), 32'd6);
    // single FIFO with two words
    do_reset();
    push(2, 8'h55);
    push(2, 8'h66);
    repeat (12) tick();
    for (int i = 0; i < N; i++) chk("f2_pops", 32'(popcnt[i]), (i == 2) ? 32'd2 : 32'd0);
    chk("f2_delivered", 32'(delivered), 32'd2);
    chk("f2_quiet", 32'({m_valid, fifo_rd_en}), 32'd0);
    // fairness: FIFO 3 gets a word while FIFO 1 streams
    do_reset();
    refill1 = 1'b1;
    for (int k = 0; k < 3; k++) push(1, 8'(8'h70 + k));
    pushed3 = 0;
    for (int t = 0; t < 40 && pop_src.size() < 6; t++) begin
      tick();
      if (popcnt[1] == 1 && pushed3 == 0) begin
        push(3, 8'h3C);
        pushed3 = 1;
      end
    end
    for (int k = 0; k < 6; k++)
      chk("rr_seq", (pop_src.size() > k) ? 32'(pop_src[k]) : 32'hFFFF, 32'(exp5[k]));
    refill1 = 1'b0;
    for (int t = 0; t < 60 && (remaining() > 0 || m_valid); t++) tick();
    chk("rr_drain", 32'(remaining()), 32'd0);
    // asynchronous reset mid-burst
    do_reset();
    for (int k = 0; k < 4; k++) push(2, 8'(8'h20 + k));
    for (int t = 0; t < 10 && !m_valid; t++) tick();
    chk("arst_busy", 32'(fifo_rd_en), 32'b0100);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(m_valid), 32'd0);
    chk("arst_rden", 32'(fifo_rd_en), 32'd0);
    @(posedge clk);
    #1;
    clear_all();
    push(0, 8'h0A);
    push(3, 8'h3A);
    rst_n = 1'b1;
    cyc = 0;
    tick();
    #1;
    chk("arst_regrant", 32'(fifo_rd_en), 32'b0001);
    repeat (12) tick();
    chk("arst_drain", 32'(delivered), 32'd2);
    // randomized traffic against the scoreboard
    do_reset();
    for (int t = 0; t < 800; t++) begin
      m_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0 && q[i].size() < 8) push(i, 8'($urandom));
      tick();
    end
    m_ready = 1'b1;
    for (int t = 0; t < 300 && (remaining() > 0 || m_valid); t++) tick();
    chk("rand_drain", 32'(remaining()), 32'd0);
    chk("rand_idle", 32'(m_valid), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
